// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width,
// FSM state encoding and iteration count.
package mul_pkg;

    localparam int NUM_OF_BITS = 8;
    localparam int MUL_ITERS   = NUM_OF_BITS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/bits_adder.sv
// Ripple-carry adder: sum = num1 + num2 + carry_in, with carry_out as the
// extra bit. Purely combinational.
module bits_adder #(
    parameter int NUM_OF_BITS = 8
) (
    input  logic [NUM_OF_BITS-1:0] num1,
    input  logic [NUM_OF_BITS-1:0] num2,
    input  logic                   carry_in,
    output logic [NUM_OF_BITS-1:0] sum,
    output logic                   carry_out
);

    logic carry;

    // Ripple the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        sum   = '0;
        carry = carry_in;
        for (int i = 0; i < NUM_OF_BITS; i++) begin
            sum[i] = num1[i] ^ num2[i] ^ carry;
            carry  = (num1[i] & num2[i]) | (carry & (num1[i] ^ num2[i]));
        end
        carry_out = carry;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier (WIDTH x WIDTH -> 2*WIDTH).
// One add/shift iteration per clock through a single bits_adder, behind a
// start/busy/done handshake.
// Optional feature: define MUL_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are all zero.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = NUM_OF_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [3:0] LAST_CNT = 4'(MUL_ITERS - 1);

    mul_state_t       state, state_next;
    logic [WIDTH-1:0] m, a, q;
    logic             c;
    logic [3:0]       cnt;

    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic [WIDTH-1:0] a_add, a_shift, q_shift;
    logic             c_add;
    logic             early_term;
    logic [2*WIDTH-1:0] prod_early;

    bits_adder #(
        .NUM_OF_BITS(WIDTH)
    ) u_adder (
        .num1     (a),
        .num2     (m),
        .carry_in (1'b0),
        .sum      (sum),
        .carry_out(carry_out)
    );

`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0] r;
    logic [4:0]       shamt;

    // Remaining multiplier bits are zero: the rest of the run is pure shifting.
    always_comb begin
        shamt      = 5'(MUL_ITERS) - {1'b0, cnt};
        early_term = (r == '0);
        prod_early = {a, q} >> shamt;
    end

    // Unprocessed multiplier bits, consumed in step with Q.
    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
        end else if (state == IDLE && start) begin
            r <= multiplier;
        end else if (state == RUN && !early_term) begin
            r <= r >> 1;
        end
    end
`else
    assign early_term = 1'b0;
    assign prod_early = {a, q};
`endif

    // Conditional add of M, then the one-bit right shift of {C,A,Q}.
    always_comb begin
        // C is always zero between iterations, so passing it through equals clearing it.
        if (q[0]) begin
            {c_add, a_add} = {carry_out, sum};
        end else begin
            {c_add, a_add} = {c, a};
        end
        a_shift = {c_add, a_add[WIDTH-1:1]};
        q_shift = {a_add[0], q[WIDTH-1:1]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (early_term || cnt == LAST_CNT) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and product register.
    always_ff @(posedge clk) begin
        if (reset) begin
            m       <= '0;
            a       <= '0;
            q       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= multiplicand;
                        q   <= multiplier;
                        a   <= '0;
                        c   <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (early_term) begin
                        product <= prod_early;
                    end else begin
                        a   <= a_shift;
                        q   <= q_shift;
                        c   <= 1'b0;
                        cnt <= cnt + 4'd1;
                        if (cnt == LAST_CNT) begin
                            product <= {a_shift, q_shift};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus pushes expected
// product and completion cycle; a monitor pops and compares on each done.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] prod;
        int          done_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    shift_add_multiplier dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: product=%h at cycle %0d with no result pending", product, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_product"}, product, e.prod);
                checks++;
                if (cyc != e.done_cyc) begin
                    errors++;
                    $display("FAIL %s_latency: done at cycle %0d required cycle %0d", e.name, cyc, e.done_cyc);
                end
            end
        end
    end

    // Drive one start request; returns at the negedge after the accepting edge E0.
    task automatic issue(input string name, input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] prod, input int lat, input bit expect_result);
        exp_t e;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        if (expect_result) begin
            e.prod     = prod;
            e.done_cyc = cyc + 1 + lat;
            e.name     = name;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        check({name, "_busy_after_E0"}, {15'd0, busy}, 16'd1);
    endtask

    // Bounded wait for all pending results, then busy must be low.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results pending required 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
        check({name, "_busy_after_done"}, {15'd0, busy}, 16'd0);
        check({name, "_done_low_after"}, {15'd0, done}, 16'd0);
    endtask

    task automatic run(input string name, input logic [7:0] m, input logic [7:0] q,
                       input logic [15:0] prod, input int et_lat);
        int lat;
`ifdef MUL_EARLY_TERM_EN
        lat = et_lat;
`else
        lat = 8;
`endif
        issue(name, m, q, prod, lat, 1'b1);
        wait_idle(name);
    endtask

    initial begin
        int lat;
        // Reset for two edges with start asserted.
        reset = 1'b1;
        start = 1'b1;
        multiplicand = 8'hAA;
        multiplier   = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_product", product, 16'h0000);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("no_op_after_reset", {15'd0, busy}, 16'd0);

        run("m13x11", 8'd13, 8'd11, 16'h008F, 5);
        run("m255x255", 8'd255, 8'd255, 16'hFE01, 8);
        run("m0x200", 8'd0, 8'd200, 16'h0000, 8);

        // Second start at E4 must be ignored.
`ifdef MUL_EARLY_TERM_EN
        lat = 4;
`else
        lat = 8;
`endif
        issue("m3x4", 8'd3, 8'd4, 16'h000C, lat, 1'b1);
        repeat (3) @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd7;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("m3x4");

        // Abort mid-run: reset between E4 and E5.
        issue("m100x100", 8'd100, 8'd100, 16'h0000, 8, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_product", product, 16'h0000);
        check("abort_done", {15'd0, done}, 16'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_stays_idle", {15'd0, busy}, 16'd0);

        run("m2x3", 8'd2, 8'd3, 16'h0006, 3);
        run("m200x1", 8'd200, 8'd1, 16'h00C8, 2);
        run("m77x0", 8'd77, 8'd0, 16'h0000, 1);
        run("m5x128", 8'd5, 8'd128, 16'h0280, 8);
        check("product_held", product, 16'h0280);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_at_end: %0d results pending required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
